simmem_resp_bank: RTL and testbench



---
 rtl/simmem_resp_bank.sv | 166 ++++++++++++++++
 tb/tb_simmem_resp_bank.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_resp_bank.sv
// Response bank: per-AXI-ID linked lists in a shared slot array, released under per-ID enables.
// Optional `SIMMEM_RESP_BANK_RR_ARB_EN selects round-robin arbitration instead of lowest-index priority.
module simmem_resp_bank #(
    parameter int StructWidth = 64,
    parameter int IDWidth     = 2,
    parameter int Capacity    = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [StructWidth-1:0]         in_data_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [(2**IDWidth)-1:0]        release_en_i,
    output logic [StructWidth-1:0]         out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [(2**IDWidth)-1:0]        released_onehot_o,
    output logic [$clog2(Capacity+1)-1:0]  occupancy_o
);
    localparam int NumIds = 2 ** IDWidth;
    localparam int PtrW   = $clog2(Capacity);
    localparam int OccW   = $clog2(Capacity + 1);

    // Valid/ready: a transfer happens on a clock edge where both valid and ready are high.

    logic [Capacity-1:0]    slot_valid;
    logic [StructWidth-1:0] slot_data [Capacity];
    logic [PtrW-1:0]        slot_next [Capacity];
    logic [PtrW-1:0]        head [NumIds];
    logic [PtrW-1:0]        tail [NumIds];
    logic [NumIds-1:0]      nonempty;
    logic [OccW-1:0]        occ;

    logic [PtrW-1:0]        free_idx;
    logic                   free_found;
    logic [NumIds-1:0]      eligible;
    logic [IDWidth-1:0]     sel_id;
    logic                   sel_found;
    logic [IDWidth-1:0]     push_id;
    logic [PtrW-1:0]        pop_slot;
    logic                   push;
    logic                   pop;
    logic [NumIds-1:0]      push_vec;
    logic [NumIds-1:0]      pop_vec;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < Capacity; i++) begin
            if (!slot_valid[i] && !free_found) begin
                free_idx   = PtrW'(i);
                free_found = 1'b1;
            end
        end
    end

    assign eligible = nonempty & release_en_i;

`ifdef SIMMEM_RESP_BANK_RR_ARB_EN
    logic [IDWidth-1:0] last_id;
    logic [IDWidth-1:0] cand;

    // Search begins one past the last served ID and wraps modulo NumIds.
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NumIds; i++) begin
            cand = last_id + IDWidth'(i + 1);
            if (eligible[cand] && !sel_found) begin
                sel_id    = cand;
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_id <= IDWidth'(NumIds - 1);
        end else if (pop) begin
            last_id <= sel_id;
        end
    end
`else
    always_comb begin
        sel_id    = '0;
        sel_found = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            if (eligible[i] && !sel_found) begin
                sel_id    = IDWidth'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    assign in_ready_o  = (occ != OccW'(Capacity));
    assign occupancy_o = occ;
    assign out_valid_o = sel_found;
    assign push_id     = in_data_i[IDWidth-1:0];
    assign pop_slot    = head[sel_id];
    assign push        = in_valid_i && in_ready_o && !rst_i;
    assign pop         = sel_found && out_ready_i && !rst_i;
    assign out_data_o  = sel_found ? slot_data[pop_slot] : '0;
    assign push_vec    = push ? (NumIds'(1) << push_id) : '0;
    assign pop_vec     = pop ? (NumIds'(1) << sel_id) : '0;
    assign released_onehot_o = pop_vec;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_valid <= '0;
            nonempty   <= '0;
            occ        <= '0;
            for (int k = 0; k < NumIds; k++) begin
                head[k] <= '0;
                tail[k] <= '0;
            end
        end else begin
            if (pop) begin
                slot_valid[pop_slot] <= 1'b0;
            end
            if (push) begin
                slot_valid[free_idx] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + OccW'(1);
                2'b01:   occ <= occ - OccW'(1);
                default: occ <= occ;
            endcase
            for (int k = 0; k < NumIds; k++) begin
                if (pop_vec[k] && push_vec[k]) begin
                    // A single-entry list hands both pointers to the new slot and stays non-empty.
                    tail[k] <= free_idx;
                    if (head[k] == tail[k]) begin
                        head[k] <= free_idx;
                    end else begin
                        head[k] <= slot_next[head[k]];
                    end
                end else if (pop_vec[k]) begin
                    if (head[k] == tail[k]) begin
                        nonempty[k] <= 1'b0;
                    end else begin
                        head[k] <= slot_next[head[k]];
                    end
                end else if (push_vec[k]) begin
                    tail[k] <= free_idx;
                    if (!nonempty[k]) begin
                        head[k]     <= free_idx;
                        nonempty[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Payload and link storage are not reset; slot_valid and the list flags gate every use.
    always_ff @(posedge clk_i) begin
        if (push) begin
            slot_data[free_idx] <= in_data_i;
            if (nonempty[push_id]) begin
                slot_next[tail[push_id]] <= free_idx;
            end
        end
    end

endmodule

// File: tb/tb_simmem_resp_bank.sv
// Bench for simmem_resp_bank: directed vectors plus a per-ID scoreboard checked by a monitor.
// Build with +define+SIMMEM_RESP_BANK_RR_ARB_EN to check the round-robin variant.
module tb_simmem_resp_bank;
    localparam int SW  = 64;
    localparam int NID = 4;
    localparam int CAP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NID-1:0] release_en = '0;
    logic [SW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NID-1:0] released_onehot;
    logic [3:0]    occupancy;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] exp_q [NID][$];
    logic [SW-1:0] pop_log [$];
    logic [SW-1:0] exp_seq [$];
    int            occ_m = 0;
    int            last_m = NID - 1;

    simmem_resp_bank #(.StructWidth(SW), .IDWidth(2), .Capacity(CAP)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .release_en_i(release_en),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .released_onehot_o(released_onehot), .occupancy_o(occupancy)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drivers (inputs change 1 time unit after the rising edge)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_msg(input logic [SW-1:0] d);
        logic ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        check("push_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic compare_log(input string name);
        check({name, "_len"}, 64'(pop_log.size()), 64'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i < pop_log.size()) check(name, pop_log[i], exp_seq[i]);
        end
    endtask

    // Monitor / scoreboard: state the DUT should hold before the coming edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_released", SW'(released_onehot), '0);
                for (int k = 0; k < NID; k++) exp_q[k].delete();
                occ_m  = 0;
                last_m = NID - 1;
            end else begin
                logic [NID-1:0] elig;
                logic           ev;
                int             sel;
                logic           do_pop;
                logic           do_push;
                elig = '0;
                for (int k = 0; k < NID; k++) elig[k] = (exp_q[k].size() > 0) && release_en[k];
                ev  = |elig;
                sel = 0;
`ifdef SIMMEM_RESP_BANK_RR_ARB_EN
                for (int i = NID; i >= 1; i--) begin
                    if (elig[(last_m + i) % NID]) sel = (last_m + i) % NID;
                end
`else
                for (int i = NID - 1; i >= 0; i--) begin
                    if (elig[i]) sel = i;
                end
`endif
                check("in_ready", SW'(in_ready), SW'(occ_m != CAP));
                check("occupancy", SW'(occupancy), SW'(occ_m));
                check("out_valid", SW'(out_valid), SW'(ev));
                check("out_data", out_data, ev ? exp_q[sel][0] : '0);
                do_pop  = ev && out_ready;
                do_push = in_valid && (occ_m != CAP);
                check("released", SW'(released_onehot), do_pop ? SW'(1 << sel) : '0);
                if (do_pop) begin
                    pop_log.push_back(exp_q[sel].pop_front());
                    last_m = sel;
                end
                if (do_push) exp_q[in_data[1:0]].push_back(in_data);
                occ_m = occ_m + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
            end
        end
    end

    initial begin
        int pidx;
        do_reset();

        // Held messages, then released in order
        out_ready = 1'b1;
        push_msg(64'hA1);
        push_msg(64'hB1);
        @(negedge clk);
        check("t1_occ_held", SW'(occupancy), 64'd2);
        check("t1_valid_held", SW'(out_valid), 64'd0);
        pop_log.delete();
        step();
        release_en = 4'b0010;
        repeat (3) step();
        @(negedge clk);
        check("t1_occ_drained", SW'(occupancy), 64'd0);
        exp_seq = '{64'hA1, 64'hB1};
        compare_log("t1_order");

        // Fill all slots; a pop in the full cycle must not admit a push
        step();
        release_en = '0;
        out_ready  = 1'b0;
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < NID; k++) push_msg(64'h2000 | 64'(j << 4) | 64'(k));
        release_en = 4'b1111;
        out_ready  = 1'b1;
        in_data    = 64'h2F02;
        in_valid   = 1'b1;
        @(negedge clk);
        check("t2_full_ready", SW'(in_ready), 64'd0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("t2_after_ready", SW'(in_ready), 64'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check("t2_occ_drained", SW'(occupancy), 64'd0);

        // Single entry in ID 2: pop and push together
        step();
        out_ready  = 1'b0;
        release_en = 4'b0100;
        push_msg(64'h32);
        in_data   = 64'h42;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("t3_valid", SW'(out_valid), 64'd1);
        check("t3_data", out_data, 64'h42);
        check("t3_occ", SW'(occupancy), 64'd1);
        step();
        out_ready = 1'b1;
        repeat (2) step();

        // Arbitration between IDs 0 and 3
        release_en = '0;
        out_ready  = 1'b0;
        do_reset();
        push_msg(64'h10);
        push_msg(64'h20);
        push_msg(64'h30);
        push_msg(64'h13);
        push_msg(64'h23);
        push_msg(64'h33);
        pop_log.delete();
        release_en = 4'b1001;
        out_ready  = 1'b1;
        repeat (8) step();
`ifdef SIMMEM_RESP_BANK_RR_ARB_EN
        exp_seq = '{64'h10, 64'h13, 64'h20, 64'h23, 64'h30, 64'h33};
`else
        exp_seq = '{64'h10, 64'h20, 64'h30, 64'h13, 64'h23, 64'h33};
`endif
        compare_log("t4_arb");

        // Random enables and backpressure, pushes to IDs 0,1,0,1,0
        pidx = 0;
        for (int c = 0; c < 2000; c++) begin
            release_en = 4'($urandom_range(0, 15));
            out_ready  = ($urandom_range(0, 3) != 0);
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = {$urandom, $urandom};
            in_data[1:0] = 2'((pidx % 5) % 2);
            @(negedge clk);
            if (in_valid && in_ready) pidx++;
            step();
        end
        in_valid   = 1'b0;
        release_en = 4'b1111;
        out_ready  = 1'b1;
        repeat (10) step();

        // Reset with five stored entries
        release_en = '0;
        out_ready  = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) push_msg(64'h500 | 64'(k << 4) | 64'(k % NID));
        rst        = 1'b1;
        release_en = 4'b1111;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = 64'h5F1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t6_occ", SW'(occupancy), 64'd0);
        check("t6_valid", SW'(out_valid), 64'd0);
        step();

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
